// File: rtl/count_sampler_fifo.sv
// Decimating sampler for the upstream 8-bit counter: every SAMPLE_DIV cycles the
// count is tagged with a 4-bit sequence number and queued in a DEPTH-entry FIFO.
module count_sampler_fifo #(
  parameter int SAMPLE_DIV = 4,
  parameter int DEPTH      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] count,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [3:0] out_seq,
  output logic [4:0] level,
  output logic       overflow,
  output logic [7:0] drop_cnt
);

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [4:0] LEVEL_FULL = 5'(DEPTH);

  logic [DIV_W-1:0] div_reg;
  logic [3:0]       seq_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [4:0]       level_reg;
  logic [4:0]       level_next;
  logic             overflow_reg;
  logic [7:0]       drop_cnt_reg;
  logic [11:0]      mem [DEPTH];

  logic strobe;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign strobe = (div_reg == DIV_LAST);
  assign full   = (level_reg == LEVEL_FULL);
  assign pop    = (level_reg != 5'd0) && out_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the sample.
  assign push   = strobe && (!full || pop);
  assign drop   = strobe && full && !pop;

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + 5'd1;
      2'b01:   level_next = level_reg - 5'd1;
      default: level_next = level_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_reg      <= '0;
      seq_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      div_reg   <= strobe ? '0 : div_reg + 1'b1;
      level_reg <= level_next;
      // Sequence advances on every strobe so drops show up as gaps downstream.
      if (strobe)
        seq_reg <= seq_reg + 4'd1;
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 8'hFF)
          drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  // Storage is cleared by reset so the head reads zero straight out of reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          mem[gi] <= '0;
        else if (push && (wr_ptr_reg == PTR_W'(gi)))
          mem[gi] <= {seq_reg, count};
      end
    end
  endgenerate

  assign out_valid = (level_reg != 5'd0);
  assign out_data  = mem[rd_ptr_reg][7:0];
  assign out_seq   = mem[rd_ptr_reg][11:8];
  assign level     = level_reg;
  assign overflow  = overflow_reg;
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_count_sampler_fifo.sv
// Directed bench for count_sampler_fifo: sampling, backpressure, full+pop,
// wrap-around, drop saturation and asynchronous reset mid-operation.
module tb_count_sampler_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] count;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [3:0] out_seq;
  logic [4:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;

  int tests;
  int fails;
  int edge_idx;
  int offset;

  count_sampler_fifo #(.SAMPLE_DIV(4), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .count     (count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_seq   (out_seq),
    .level     (level),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready)
      $display("[TB] pop data=%0d seq=%0d", out_data, out_seq);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Edge index e sees count = offset + e (mod 256), like a free-running counter.
  task automatic step();
    count = 8'(offset + edge_idx);
    @(posedge clk);
    #1;
    edge_idx++;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic restart();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    edge_idx = 0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    edge_idx = 0;
    offset = 0;
    reset = 1'b1;
    count = 8'd0;
    out_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_seq", 32'(out_seq), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    // Basic sampling with a consumer that is always ready
    out_ready = 1'b1;
    restart();
    for (int k = 0; k < 4; k++) begin
      steps(3);
      chk("t1_empty_before_strobe", 32'(out_valid), 32'd0);
      step();
      chk("t1_data", 32'(out_data), 32'(4 * k + 3));
      chk("t1_seq", 32'(out_seq), 32'(k));
      chk("t1_level", 32'(level), 32'd1);
    end
    step();
    chk("t1_drained", 32'(level), 32'd0);
    chk("t1_ovf", 32'(overflow), 32'd0);

    // Backpressure, fill and drop
    out_ready = 1'b0;
    restart();
    steps(16);
    chk("t2_full_level", 32'(level), 32'd4);
    chk("t2_head_data", 32'(out_data), 32'd3);
    chk("t2_head_seq", 32'(out_seq), 32'd0);
    steps(3);
    chk("t2_no_ovf_yet", 32'(overflow), 32'd0);
    step();
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_drop", 32'(drop_cnt), 32'd1);
    chk("t2_level_hold", 32'(level), 32'd4);
    chk("t2_head_stable", 32'(out_data), 32'd3);
    out_ready = 1'b1;
    step();
    chk("t2_pop1_data", 32'(out_data), 32'd7);
    chk("t2_pop1_seq", 32'(out_seq), 32'd1);
    chk("t2_pop1_level", 32'(level), 32'd3);
    steps(2);
    chk("t2_pop3_data", 32'(out_data), 32'd15);
    chk("t2_pop3_seq", 32'(out_seq), 32'd3);
    step();
    chk("t2_gap_data", 32'(out_data), 32'd23);
    chk("t2_gap_seq", 32'(out_seq), 32'd5);
    chk("t2_gap_level", 32'(level), 32'd1);

    // Full with a pop on exactly the strobe edge
    out_ready = 1'b0;
    restart();
    steps(19);
    chk("t3_full", 32'(level), 32'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t3_level_kept", 32'(level), 32'd4);
    chk("t3_no_drop", 32'(drop_cnt), 32'd0);
    chk("t3_no_ovf", 32'(overflow), 32'd0);
    chk("t3_head_data", 32'(out_data), 32'd7);
    chk("t3_head_seq", 32'(out_seq), 32'd1);
    out_ready = 1'b1;
    steps(3);
    chk("t3_tail_data", 32'(out_data), 32'd19);
    chk("t3_tail_seq", 32'(out_seq), 32'd4);
    chk("t3_tail_level", 32'(level), 32'd1);

    // Count wrap-around and sequence/pointer wrap
    out_ready = 1'b1;
    offset = 250;
    restart();
    steps(4);
    chk("t4_s0_data", 32'(out_data), 32'd253);
    chk("t4_s0_seq", 32'(out_seq), 32'd0);
    steps(4);
    chk("t4_s1_data", 32'(out_data), 32'd1);
    steps(4);
    chk("t4_s2_data", 32'(out_data), 32'd5);
    chk("t4_s2_seq", 32'(out_seq), 32'd2);
    steps(52);
    chk("t4_s15_data", 32'(out_data), 32'd57);
    chk("t4_s15_seq", 32'(out_seq), 32'd15);
    steps(4);
    chk("t4_s16_data", 32'(out_data), 32'd61);
    chk("t4_s16_seq", 32'(out_seq), 32'd0);
    offset = 0;

    // Drop counter saturation
    out_ready = 1'b0;
    restart();
    steps(1032);
    chk("t5_drop_254", 32'(drop_cnt), 32'd254);
    chk("t5_ovf", 32'(overflow), 32'd1);
    steps(4);
    chk("t5_drop_255", 32'(drop_cnt), 32'd255);
    steps(164);
    chk("t5_drop_hold", 32'(drop_cnt), 32'd255);
    chk("t5_level", 32'(level), 32'd4);
    chk("t5_head", 32'(out_data), 32'd3);

    // Asynchronous reset between edges
    out_ready = 1'b0;
    restart();
    steps(20);
    chk("t6_pre_drop", 32'(drop_cnt), 32'd1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t6_level3", 32'(level), 32'd3);
    chk("t6_pre_ovf", 32'(overflow), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_level", 32'(level), 32'd0);
    chk("t6_async_ovf", 32'(overflow), 32'd0);
    chk("t6_async_drop", 32'(drop_cnt), 32'd0);
    chk("t6_async_data", 32'(out_data), 32'd0);
    #1;
    reset = 1'b0;
    edge_idx = 0;
    steps(3);
    chk("t6_no_early_strobe", 32'(level), 32'd0);
    step();
    chk("t6_first_level", 32'(level), 32'd1);
    chk("t6_first_seq", 32'(out_seq), 32'd0);
    chk("t6_first_data", 32'(out_data), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
